data_mem_pipe: RTL

//   Parametrised successor to the single-cycle data memory, for the pipelined 16-bit MIPS core.
//   - Accepts load/store requests over a valid/ready handshake and returns responses after a fixed,

---
 rtl/data_mem_pkg.sv | 19 +
 rtl/data_mem_pipe_if.sv | 33 +++
 rtl/data_mem_rsp_pipe.sv | 63 ++++++
 rtl/data_mem_pipe.sv | 127 ++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module : data_mem_pkg
// Brief  : FSM encoding, latency limit and byte-lane helper for data_mem_pipe.
// Rev    : 1.0
// ============================================================================
package data_mem_pkg;

  localparam int RD_LAT_MAX = 3;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;

  function automatic logic [7:0] byte_lane_mask(input logic be_bit);
    return {8{be_bit}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_pipe_if.sv
`default_nettype none
// ============================================================================
// Module : data_mem_pipe_if
// Brief  : Request/response bundle between the MEM stage and data_mem_pipe.
// Rev    : 1.0
// ============================================================================
interface data_mem_pipe_if #(
  parameter int DATA_W = 16
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [15:0]           req_addr;
  logic [DATA_W/8-1:0]   req_be;
  logic [DATA_W-1:0]     req_wdata;
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;
  logic                  busy;

  modport master (
    output req_valid, req_we, req_addr, req_be, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_be, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

endinterface
`default_nettype wire

// File: rtl/data_mem_rsp_pipe.sv
`default_nettype none
// ============================================================================
// Module : data_mem_rsp_pipe
// Brief  : Fixed-depth response shift register {valid, err, rdata}, flushed on rst.
// Rev    : 1.0
// ============================================================================
module data_mem_rsp_pipe
  import data_mem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_err,
  input  logic [DATA_W-1:0] in_rdata,
  output logic              out_valid,
  output logic              out_err,
  output logic [DATA_W-1:0] out_rdata
);

  // Out-of-range latencies are clamped so the pipe always has 1..RD_LAT_MAX stages.
  localparam int STAGES = (LAT < 1) ? 1 : ((LAT > RD_LAT_MAX) ? RD_LAT_MAX : LAT);

  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] err_q, err_d;
  logic [DATA_W-1:0] rdata_q [STAGES];
  logic [DATA_W-1:0] rdata_d [STAGES];

  always_comb begin
    valid_d[0] = in_valid;
    err_d[0]   = in_err;
    rdata_d[0] = in_rdata;
    for (int s = 1; s < STAGES; s++) begin
      valid_d[s] = valid_q[s-1];
      err_d[s]   = err_q[s-1];
      rdata_d[s] = rdata_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      err_q   <= '0;
      for (int s = 0; s < STAGES; s++) begin
        rdata_q[s] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      err_q   <= err_d;
      for (int s = 0; s < STAGES; s++) begin
        rdata_q[s] <= rdata_d[s];
      end
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign out_err   = err_q[STAGES-1];
  assign out_rdata = rdata_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/data_mem_pipe.sv
`default_nettype none
// ============================================================================
// Module : data_mem_pipe
// Brief  : Pipelined data RAM with byte enables, range check and post-reset clear.
// Rev    : 1.0
// ============================================================================
module data_mem_pipe
  import data_mem_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int DEPTH        = 256,
  parameter int RD_LAT       = 1,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic            clk,
  input  logic            rst,
  data_mem_pipe_if.slave  bus
);

  localparam int         BE_W       = DATA_W / 8;
  localparam int         ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [0:0] ST_AFTER_RST = (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              ready;
  logic              accept;
  logic              in_range;
  logic [ADDR_W-1:0] req_idx;
  logic [DATA_W-1:0] be_mask;
  logic [DATA_W-1:0] rd_word;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic              pipe_in_err;
  logic [DATA_W-1:0] pipe_in_rdata;
  logic              pipe_valid;
  logic              pipe_err;
  logic [DATA_W-1:0] pipe_rdata;

  for (genvar i = 0; i < BE_W; i++) begin : g_lane
    assign be_mask[8*i +: 8] = byte_lane_mask(bus.req_be[i]);
  end

  always_comb begin
    in_range = (32'(bus.req_addr) < DEPTH);
    req_idx  = bus.req_addr[ADDR_W-1:0];
    rd_word  = mem_q[req_idx];
    ready    = !rst && (state_q == ST_IDLE);
    accept   = bus.req_valid && ready;
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    if (state_q == ST_CLEAR) begin
      clr_ptr_d = clr_ptr_q + ADDR_W'(1);
      if (clr_ptr_q == ADDR_W'(DEPTH - 1)) begin
        state_d   = ST_IDLE;
        clr_ptr_d = '0;
      end
    end
  end

  // One write port shared by the clear sweep and stores; they never overlap
  // because requests are refused while clearing.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = req_idx;
    wr_data = (rd_word & ~be_mask) | (bus.req_wdata & be_mask);
    if (!rst && (state_q == ST_CLEAR)) begin
      wr_en   = 1'b1;
      wr_idx  = clr_ptr_q;
      wr_data = '0;
    end else if (accept && bus.req_we && in_range) begin
      wr_en   = 1'b1;
    end
  end

  always_comb begin
    pipe_in_err   = accept && !in_range;
    pipe_in_rdata = (accept && !bus.req_we && in_range) ? rd_word : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_AFTER_RST;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  data_mem_rsp_pipe #(
    .DATA_W (DATA_W),
    .LAT    (RD_LAT)
  ) u_rsp_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (accept),
    .in_err    (pipe_in_err),
    .in_rdata  (pipe_in_rdata),
    .out_valid (pipe_valid),
    .out_err   (pipe_err),
    .out_rdata (pipe_rdata)
  );

  // Outputs are forced low for the whole reset, including its first cycle.
  always_comb begin
    bus.req_ready = ready;
    bus.busy      = !rst && (state_q == ST_CLEAR);
    bus.rsp_valid = !rst && pipe_valid;
    bus.rsp_err   = !rst && pipe_valid && pipe_err;
    bus.rsp_rdata = (!rst && pipe_valid) ? pipe_rdata : '0;
  end

endmodule
`default_nettype wire
